chaos_scan_ctrl: RTL

- Upstream driver for the logistic-map display stage: generates 640x480 VGA scan timing (row, col, sync, video enable) and the map parameter mu, with maxrepeat.
- mu is stepped by push buttons or swept automatically.
- Changes are applied only at vertical-blank start. The logistic iteration units are then restarted through an active-low restart strobe, so each frame shows one consistent mu.

---
 rtl/chaos_scan_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/chaos_scan_ctrl.sv
// chaos_scan_ctrl: VGA scan timing plus mu / restart control for the
// logistic-map display stage.
//
// Ports:
//   CLK, RST           pixel clock, async active-low reset
//   btn_up, btn_down   async push buttons, step mu up / down
//   sweep_en           level, 1 = automatic mu sweep
//   row, col           scan position
//   hsync, vsync       active-low syncs
//   video_on           1 inside the visible area
//   frame_start        one-cycle pulse at row=0, col=0
//   mu                 map parameter (16 fractional bits)
//   maxrepeat          iteration count (constant)
//   cyc_rst            active-low restart strobe for iteration units

module chaos_scan_ctrl #(
    parameter int          H_VIS        = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_VIS        = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [17:0] MU_INIT      = 18'h3_0000,
    parameter logic [17:0] MU_MIN       = 18'h2_8000,
    parameter logic [17:0] MU_MAX       = 18'h3_FF00,
    parameter logic [17:0] MU_STEP      = 18'h0_0100,
    parameter int          SWEEP_FRAMES = 4,
    parameter logic [8:0]  MAXREP       = 9'd400
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        sweep_en,
    output logic [9:0]  row,
    output logic [9:0]  col,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic [17:0] mu,
    output logic [8:0]  maxrepeat,
    output logic        cyc_rst
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VISC = 10'(H_VIS);
    localparam logic [9:0] V_VISC = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    localparam int FCW =
        (SWEEP_FRAMES > 1) ? $clog2(SWEEP_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(SWEEP_FRAMES - 1);

    localparam logic [18:0] MAX_W = {1'b0, MU_MAX};
    localparam logic [18:0] MIN_W = {1'b0, MU_MIN};

    typedef enum logic {RUN, RESTART} state_t;

    state_t         state, state_d;
    logic [9:0]     col_n, row_n;
    logic [1:0]     up_sync, dn_sync;
    logic           up_prev, dn_prev;
    logic           up_edge, dn_edge;
    logic           pend_up, pend_dn, pend_sweep;
    logic [FCW-1:0] frame_cnt;
    logic           apply;
    logic [18:0]    mu_inc, mu_dec;
    logic [17:0]    mu_calc, mu_d;
    logic           cyc_rst_d;

    assign maxrepeat = MAXREP;

    // Next counter values; all timing outputs are decoded from these
    // so that they line up with the registered row/col.
    always_comb begin
        col_n = col + 10'd1;
        row_n = row;
        if (col == H_LAST) begin
            col_n = '0;
            row_n = (row == V_LAST) ? '0 : row + 10'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col         <= '0;
            row         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            col         <= col_n;
            row         <= row_n;
            hsync       <= !(col_n >= HS_BEG && col_n < HS_END);
            vsync       <= !(row_n >= VS_BEG && row_n < VS_END);
            video_on    <= (col_n < H_VISC) && (row_n < V_VISC);
            frame_start <= (col_n == '0) && (row_n == '0);
        end
    end

    // First line of vertical blank: the only point where mu moves.
    assign apply = (row == V_VISC) && (col == '0);

    assign up_edge = up_sync[1] & ~up_prev;
    assign dn_edge = dn_sync[1] & ~dn_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            up_sync <= '0;
            dn_sync <= '0;
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_sync <= {up_sync[0], btn_up};
            dn_sync <= {dn_sync[0], btn_down};
            up_prev <= up_sync[1];
            dn_prev <= dn_sync[1];
        end
    end

    // An edge landing on the apply cycle itself survives the clear
    // and is carried into the next frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_up    <= 1'b0;
            pend_dn    <= 1'b0;
            pend_sweep <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            pend_up <= (pend_up & ~apply) | up_edge;
            pend_dn <= (pend_dn & ~apply) | dn_edge;
            if (!sweep_en) begin
                pend_sweep <= 1'b0;
                frame_cnt  <= '0;
            end else if (apply && (pend_up || pend_dn)) begin
                pend_sweep <= 1'b0;
                frame_cnt  <= '0;
            end else begin
                pend_sweep <= pend_sweep & ~apply;
                if (frame_start) begin
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt  <= '0;
                        pend_sweep <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // 19-bit arithmetic keeps the carry visible to the bound checks.
    assign mu_inc = {1'b0, mu} + {1'b0, MU_STEP};
    assign mu_dec = {1'b0, mu} - {1'b0, MU_STEP};

    always_comb begin
        mu_calc = mu;
        if (pend_up && pend_dn) begin
            mu_calc = mu;
        end else if (pend_up) begin
            mu_calc = (mu_inc > MAX_W) ? MU_MAX : mu_inc[17:0];
        end else if (pend_dn) begin
            mu_calc = (mu_dec[18] || mu_dec < MIN_W)
                    ? MU_MIN : mu_dec[17:0];
        end else if (pend_sweep) begin
            mu_calc = (mu_inc > MAX_W) ? MU_MIN : mu_inc[17:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= RUN;
            mu      <= MU_INIT;
            cyc_rst <= 1'b0;
        end else begin
            state   <= state_d;
            mu      <= mu_d;
            cyc_rst <= cyc_rst_d;
        end
    end

    always_comb begin
        state_d   = state;
        mu_d      = mu;
        cyc_rst_d = 1'b1;
        unique case (state)
            RUN: begin
                if (apply && (mu_calc != mu)) begin
                    mu_d      = mu_calc;
                    cyc_rst_d = 1'b0;
                    state_d   = RESTART;
                end
            end
            RESTART: begin
                state_d = RUN;
            end
        endcase
    end

endmodule
